timing_sequencer: RTL and testbench

- Generates the 5-bit timing-step code T that drives the 5-to-32 step decoder of the hardwired control unit. That decoder turns T into one-hot timing signals.
- Advances T once per clock while running.
- Restarts T at each instruction end.
- Redirects T into the interrupt micro-sequence at instruction boundaries.
- Provides run, halt and single-step control plus an instruction counter.

---
 rtl/timing_sequencer_if.sv | 30 +++
 rtl/timing_sequencer.sv | 109 ++++++++++
 tb/tb_timing_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/timing_sequencer_if.sv
// Control/status bundle between the hardwired control unit and the
// timing-step sequencer. The control unit owns the master side.
interface timing_sequencer_if #(
  parameter int T_W   = 5,
  parameter int CNT_W = 16
);
  logic             start;
  logic             step_req;
  logic             halt_req;
  logic             stall;
  logic             clr;
  logic             irq;
  logic             ien;
  logic [T_W-1:0]   t;
  logic             boundary;
  logic             irq_ack;
  logic             running;
  logic             seq_err;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output start, step_req, halt_req, stall, clr, irq, ien,
    input  t, boundary, irq_ack, running, seq_err, instr_cnt
  );

  modport slave (
    input  start, step_req, halt_req, stall, clr, irq, ien,
    output t, boundary, irq_ack, running, seq_err, instr_cnt
  );
endinterface

// File: rtl/timing_sequencer.sv
// Timing-step sequencer: produces the registered step code T for the 5-to-32
// step decoder, restarts it at instruction end, diverts into the interrupt
// micro-sequence at boundaries, and provides run/halt/single-step control.
module timing_sequencer #(
  parameter int T_W      = 5,
  parameter int MAX_STEP = 31,
  parameter int INT_BASE = 24,
  parameter int CNT_W    = 16
) (
  input logic             clk,
  input logic             rst_n,
  timing_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, HALT, STEP} state_t;

  localparam logic [T_W-1:0] TMAX  = T_W'(MAX_STEP);
  localparam logic [T_W-1:0] TINT  = T_W'(INT_BASE);

  state_t           state_q, state_d;
  logic [T_W-1:0]   t_q, t_d;
  logic             bnd_q, bnd_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register: every visible output is a flop so the decoder never sees X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      bnd_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      bnd_q   <= bnd_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: run/halt control plus step advance and boundary redirection.
  // Pulses default low so a stalled cycle never raises BOUNDARY/IRQ_ACK.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    bnd_d   = 1'b0;
    ack_d   = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, HALT: begin
        t_d = '0;
        if (bus.start) begin
          state_d = RUN;
          bnd_d   = 1'b1;
          err_d   = 1'b0;
        end else if (state_q == HALT && bus.step_req) begin
          state_d = STEP;
          bnd_d   = 1'b1;
        end
      end
      RUN, STEP: begin
        if (!bus.stall) begin
          if (bus.clr) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == STEP || bus.halt_req) begin
              // halting wins over interrupts; a pending IRQ stays pending
              state_d = HALT;
              t_d     = '0;
            end else if (bus.irq && bus.ien) begin
              t_d   = TINT;
              ack_d = 1'b1;
            end else begin
              t_d   = '0;
              bnd_d = 1'b1;
            end
          end else if (t_q != TMAX) begin
            t_d = t_q + T_W'(1);
          end else begin
            // ran off the end of the step space without CLR
            t_d   = '0;
            err_d = 1'b1;
            bnd_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    bus.t         = t_q;
    bus.boundary  = bnd_q;
    bus.irq_ack   = ack_q;
    bus.running   = (state_q == RUN) || (state_q == STEP);
    bus.seq_err   = err_q;
    bus.instr_cnt = cnt_q;
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: overflow fault, CLR restart, stall,
// interrupt entry, halt/step control and asynchronous reset.
module tb_timing_sequencer;
  logic clk;
  logic rst_n;
  int   ntests;
  int   nfail;

  timing_sequencer_if bus ();

  timing_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    ntests = 0;
    nfail  = 0;
    rst_n  = 1'b0;
    bus.start = 0; bus.step_req = 0; bus.halt_req = 0; bus.stall = 0;
    bus.clr = 0; bus.irq = 0; bus.ien = 0;
    #1;
    chk("rst_t", 32'(bus.t), 0);
    chk("rst_bnd", 32'(bus.boundary), 0);
    chk("rst_ack", 32'(bus.irq_ack), 0);
    chk("rst_run", 32'(bus.running), 0);
    chk("rst_err", 32'(bus.seq_err), 0);
    chk("rst_cnt", 32'(bus.instr_cnt), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_t", 32'(bus.t), 0);

    // overflow without CLR
    bus.start = 1; tick(); bus.start = 0;
    chk("start_run", 32'(bus.running), 1);
    chk("start_bnd", 32'(bus.boundary), 1);
    chk("start_t", 32'(bus.t), 0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      chk("ramp_t", 32'(bus.t), 32'(i));
      chk("ramp_bnd", 32'(bus.boundary), 0);
    end
    chk("pre_ovf_err", 32'(bus.seq_err), 0);
    tick();
    chk("ovf_t", 32'(bus.t), 0);
    chk("ovf_err", 32'(bus.seq_err), 1);
    chk("ovf_bnd", 32'(bus.boundary), 1);
    chk("ovf_cnt", 32'(bus.instr_cnt), 0);

    // CLR at T=3, five instructions
    for (int k = 1; k <= 5; k++) begin
      tick(); tick(); tick();
      chk("clr_pre_t", 32'(bus.t), 3);
      bus.clr = 1; tick(); bus.clr = 0;
      chk("clr_t", 32'(bus.t), 0);
      chk("clr_bnd", 32'(bus.boundary), 1);
      chk("clr_cnt", 32'(bus.instr_cnt), 32'(k));
    end

    // stall with CLR held at T=2
    tick(); tick();
    chk("stl_pre_t", 32'(bus.t), 2);
    bus.stall = 1; bus.clr = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stl_t", 32'(bus.t), 2);
      chk("stl_cnt", 32'(bus.instr_cnt), 5);
      chk("stl_bnd", 32'(bus.boundary), 0);
    end
    bus.stall = 0; tick(); bus.clr = 0;
    chk("stl_rel_t", 32'(bus.t), 0);
    chk("stl_rel_cnt", 32'(bus.instr_cnt), 6);
    chk("stl_rel_bnd", 32'(bus.boundary), 1);

    // interrupt entry at T=4
    bus.irq = 1; bus.ien = 1;
    tick(); tick(); tick(); tick();
    chk("irq_pre_t", 32'(bus.t), 4);
    bus.clr = 1; tick(); bus.clr = 0; bus.irq = 0;
    chk("irq_t", 32'(bus.t), 24);
    chk("irq_ack", 32'(bus.irq_ack), 1);
    chk("irq_bnd", 32'(bus.boundary), 0);
    chk("irq_cnt", 32'(bus.instr_cnt), 7);
    tick();
    chk("isr_t25", 32'(bus.t), 25);
    chk("isr_ack0", 32'(bus.irq_ack), 0);
    tick();
    chk("isr_t26", 32'(bus.t), 26);
    bus.clr = 1; tick(); bus.clr = 0;
    chk("isr_end_t", 32'(bus.t), 0);
    chk("isr_end_bnd", 32'(bus.boundary), 1);
    chk("isr_end_cnt", 32'(bus.instr_cnt), 8);

    // halt beats irq, single step, restart services irq
    tick();
    bus.halt_req = 1; bus.irq = 1; bus.ien = 1; bus.clr = 1;
    tick(); bus.clr = 0; bus.halt_req = 0;
    chk("hlt_run", 32'(bus.running), 0);
    chk("hlt_t", 32'(bus.t), 0);
    chk("hlt_ack", 32'(bus.irq_ack), 0);
    chk("hlt_bnd", 32'(bus.boundary), 0);
    chk("hlt_cnt", 32'(bus.instr_cnt), 9);
    tick();
    chk("hlt_hold_t", 32'(bus.t), 0);
    chk("hlt_hold_run", 32'(bus.running), 0);
    bus.step_req = 1; tick(); bus.step_req = 0;
    chk("stp_run", 32'(bus.running), 1);
    chk("stp_bnd", 32'(bus.boundary), 1);
    tick();
    chk("stp_t", 32'(bus.t), 1);
    bus.clr = 1; tick(); bus.clr = 0;
    chk("stp_end_run", 32'(bus.running), 0);
    chk("stp_end_ack", 32'(bus.irq_ack), 0);
    chk("stp_end_t", 32'(bus.t), 0);
    chk("stp_end_cnt", 32'(bus.instr_cnt), 10);
    chk("stp_end_err", 32'(bus.seq_err), 1);
    bus.start = 1; tick(); bus.start = 0;
    chk("rs_run", 32'(bus.running), 1);
    chk("rs_bnd", 32'(bus.boundary), 1);
    chk("rs_err", 32'(bus.seq_err), 0);
    tick();
    bus.clr = 1; tick(); bus.clr = 0; bus.irq = 0;
    chk("rs_ack", 32'(bus.irq_ack), 1);
    chk("rs_t", 32'(bus.t), 24);
    chk("rs_cnt", 32'(bus.instr_cnt), 11);

    // overflow again, then async reset at T=7
    for (int k = 0; k < 8; k++) tick();
    chk("ovf2_err", 32'(bus.seq_err), 1);
    chk("ovf2_t", 32'(bus.t), 0);
    for (int k = 0; k < 7; k++) tick();
    chk("ar_pre_t", 32'(bus.t), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_t", 32'(bus.t), 0);
    chk("ar_err", 32'(bus.seq_err), 0);
    chk("ar_cnt", 32'(bus.instr_cnt), 0);
    chk("ar_run", 32'(bus.running), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ar_idle_t", 32'(bus.t), 0);
      chk("ar_idle_run", 32'(bus.running), 0);
    end
    bus.start = 1; tick(); bus.start = 0;
    chk("ar_start_bnd", 32'(bus.boundary), 1);
    tick();
    chk("ar_start_t", 32'(bus.t), 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
